// File: rtl/conv2_maxpool_stream.sv
// conv2_maxpool_stream
//   Streaming 3x3, stride-2 max-pool over one channel plane at a time.
//   Pixels arrive in raster order (IN_H x IN_W). Planes follow back-to-back.
//   The pooled OUT_H x OUT_W plane is emitted in raster order.
//   Comparisons are signed. On a tie, the earlier operand is kept.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_data   : activation pixel (signed, DATA_W bits)
//   in_valid  : in_data is valid
//   in_ready  : a beat can be accepted this cycle
//   out_data  : pooled pixel
//   out_valid : out_data is valid
//   out_ready : downstream accepts out_data
//   out_last  : marks the final pooled pixel of a plane

module conv2_maxpool_stream #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 27,
    parameter int IN_H   = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int OUT_W = (IN_W - 3) / 2 + 1;
    localparam int OUT_H = (IN_H - 3) / 2 + 1;
    localparam int CW    = $clog2(IN_W);
    localparam int RW    = $clog2(IN_H);
    localparam int JW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] vbuf [OUT_W];

    logic              accept;
    logic              h_final;
    logic              emit;
    logic              plane_end;
    logic [JW-1:0]     jdx;
    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] v_cur;
    logic [DATA_W-1:0] v_max;

    // Signed max. The tie returns a.
    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

    always_comb begin
        in_ready  = !out_valid || out_ready;
        accept    = in_valid && in_ready;
        h         = smax(hmax, in_data);
        // Window j = (c-2)/2. This value is only meaningful when h_final is set.
        jdx       = JW'((col >> 1) - CW'(1));
        v_cur     = vbuf[jdx];
        v_max     = smax(v_cur, h);
        h_final   = accept && (col != '0) && !col[0];
        emit      = h_final && (row != '0) && !row[0];
        plane_end = (row == RW'(2 * OUT_H)) && (col == CW'(2 * OUT_W));
    end

    // Column-max line buffer. Row 0 always overwrites an entry before it is read,
    // so no reset is needed. An even row seeds the next window row with h.
    always_ff @(posedge clk) begin
        if (h_final && !rst) begin
            vbuf[jdx] <= row[0] ? v_max : h;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            hmax      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (col == CW'(IN_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IN_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                // An odd column extends the window. Column 0, and an even column
                // that closes a window, both start a new window with x.
                hmax <= ((col != '0) && col[0]) ? h : in_data;
                if (emit) begin
                    out_data  <= v_max;
                    out_valid <= 1'b1;
                    out_last  <= plane_end;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2_maxpool_stream.sv
// Scoreboard bench for conv2_maxpool_stream. Each plane is held in a bench array.
// The expected 3x3/stride-2 maxima are computed directly and queued before
// the plane is driven. A negedge monitor pops and compares every transfer.
module tb_conv2_maxpool_stream;

    localparam int DW = 16;
    localparam int W  = 27;
    localparam int H  = 27;
    localparam int OW = (W - 3) / 2 + 1;
    localparam int OH = (H - 3) / 2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    always #5 clk = ~clk;

    conv2_maxpool_stream #(
        .DATA_W(DW),
        .IN_W  (W),
        .IN_H  (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t                  sb[$];
    logic signed [DW-1:0]  pix [H][W];
    int                    n_checks  = 0;
    int                    n_fail    = 0;
    int                    last_seen = 0;
    int                    last_exp  = 0;
    bit                    sb_off    = 1'b0;
    int                    ready_mode = 0;
    int                    phase     = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Downstream readiness: always high, or one cycle high in four.
    always @(posedge clk) begin
        #1;
        phase = (phase + 1) % 4;
        out_ready = (ready_mode == 0) ? 1'b1 : (phase == 0);
    end

    // Monitor. It samples mid-cycle, and a transfer happens on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !sb_off) begin
            if (out_valid && !out_ready) begin
                check_val("in_ready_stall", in_ready, 0);
                if (sb.size() != 0) begin
                    check_val("stall_data", out_data, sb[0].d);
                    check_val("stall_last", out_last, sb[0].l);
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("sb_depth", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_val("out_data", out_data, e.d);
                    check_val("out_last", out_last, e.l);
                    if (out_last) last_seen++;
                end
            end
        end
    end

    task automatic fill(input int kind, input int val);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       pix[r][c] = DW'(r * W + c);
                    1:       pix[r][c] = DW'(val);
                    default: pix[r][c] = (r == 2 && c == 2) ? DW'(val) : '0;
                endcase
    endtask

    task automatic push_expected();
        logic signed [DW-1:0] m;
        exp_t e;
        for (int i = 0; i < OH; i++) begin
            for (int j = 0; j < OW; j++) begin
                m = pix[2*i][2*j];
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        if (pix[2*i+dr][2*j+dc] > m) m = pix[2*i+dr][2*j+dc];
                e.d = m;
                e.l = (i == OH - 1) && (j == OW - 1);
                if (e.l) last_exp++;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] x);
        int waitc = 0;
        bit acc   = 1'b0;
        in_data  = x;
        in_valid = 1'b1;
        while (!acc && waitc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waitc++;
        end
        if (!acc) check_val("in_accept", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_pixels(input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(pix[k / W][k % W]);
        end
    endtask

    task automatic drive_plane(input bit gaps);
        push_expected();
        send_pixels(W * H, gaps);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Ramp plane, continuous flow.
        fill(0, 0);
        drive_plane(1'b0);
        // Single spike at (2,2).
        fill(2, 1000);
        drive_plane(1'b0);
        // Negative constant plane, then a max-positive plane, back-to-back.
        fill(1, -5);
        drive_plane(1'b0);
        fill(1, 16'h7FFF);
        drive_plane(1'b0);

        // Ramp plane with backpressure and input gaps.
        ready_mode = 1;
        fill(0, 0);
        drive_plane(1'b1);
        drain(4000);
        ready_mode = 0;
        drain(100);

        // Reset in mid-plane: partial outputs are ignored, and then a clean ramp plane follows.
        sb_off = 1'b1;
        fill(0, 0);
        send_pixels(100, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_out_valid", out_valid, 0);
        sb_off = 1'b0;
        @(posedge clk);
        #1;
        drive_plane(1'b0);

        // Consecutive constant planes.
        for (int p = 0; p < 64; p++) begin
            fill(1, p);
            drive_plane(1'b0);
        end

        drain(5000);
        check_val("sb_drain", sb.size(), 0);
        check_val("last_count", last_seen, last_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
